// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Definitions shared by the 7-segment decode and encode blocks:
//   - the segment patterns for the digits 0..9, ordered {a,b,c,d,e,f,g}
//     with bit 6 = a and bit 0 = g
//   - the code returned for a pattern that is not a digit
//   - the scan decoder FSM state encodings and its state-register struct
//   - small helpers that classify a digit-strobe value
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    // Code reported for any pattern that is not one of the ten digits.
    localparam logic [3:0] ERR_CODE = 4'hF;

    // Scan decoder FSM states.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    // All control state of the scan decoder, kept together so it can be
    // observed as one signal.
    typedef struct packed {
        logic [1:0] state;
        logic [3:0] cnt;   // consecutive identical samples seen
        logic [3:0] mask;  // digits captured since the last frame pulse
    } scan_fsm_t;

    // Exactly one strobe bit set.
    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Two or more strobe bits set.
    function automatic logic is_multi_hot(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd
//   Combinational lookup from a 7-segment pattern to a BCD digit.
//   Ports:
//     seg  [6:0] in  : active-high segments {a,b,c,d,e,f,g}
//     code [3:0] out : decoded digit 0..9, or ERR_CODE when not a digit
//     err        out : 1 when the pattern is not a digit
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       err
);

    always_comb begin
        code = ERR_CODE;
        err  = 1'b1;
        case (seg)
            SEG_0: begin code = 4'd0; err = 1'b0; end
            SEG_1: begin code = 4'd1; err = 1'b0; end
            SEG_2: begin code = 4'd2; err = 1'b0; end
            SEG_3: begin code = 4'd3; err = 1'b0; end
            SEG_4: begin code = 4'd4; err = 1'b0; end
            SEG_5: begin code = 4'd5; err = 1'b0; end
            SEG_6: begin code = 4'd6; err = 1'b0; end
            SEG_7: begin code = 4'd7; err = 1'b0; end
            SEG_8: begin code = 4'd8; err = 1'b0; end
            SEG_9: begin code = 4'd9; err = 1'b0; end
            default: begin
                code = ERR_CODE;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Watches the segment and digit-strobe lines of a 4-digit multiplexed
//   7-segment display and recovers the displayed digits. A digit is
//   captured once {dig_en, seg_in} has been sampled identical STABLE_CNT
//   times in a row with a one-hot strobe.
//   Ports:
//     clk               in  : clock, rising edge
//     rst_n             in  : asynchronous active-low reset
//     seg_in      [6:0] in  : segments {a,b,c,d,e,f,g}, bit 6 = a
//     dig_en      [3:0] in  : digit strobe, one-hot or zero
//     bcd_digits [15:0] out : digit i in bits [4i+3:4i]
//     digit_err   [3:0] out : bit i = last capture of digit i was not a digit
//     frame_valid       out : one-cycle pulse when all four digits captured
//     scan_err          out : high for each sample with several strobes set
//   The output side has no handshake: bcd_digits/digit_err change only on a
//   capture edge, and frame_valid is a single-cycle pulse with no ready.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_en,
    output logic [15:0] bcd_digits,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    output logic        scan_err
);

    localparam logic [3:0] CNT_CAPTURE = 4'(STABLE_CNT);
    localparam logic [3:0] CNT_LAST    = 4'(STABLE_CNT - 1);

    // Sample register and the sample one clock older, used for the
    // "inputs unchanged" test.
    logic [6:0]  smp_seg;
    logic [3:0]  smp_en;
    logic [6:0]  prv_seg;
    logic [3:0]  prv_en;

    scan_fsm_t   fsm_q;
    scan_fsm_t   fsm_n;

    logic [15:0] bcd_q;
    logic [15:0] bcd_n;
    logic [3:0]  err_q;
    logic [3:0]  err_n;
    logic        fv_q;
    logic        fv_n;
    logic        se_q;

    logic [3:0]  dec_code;
    logic        dec_err;
    logic        smp_one_hot;
    logic        smp_changed;
    logic        capture;
    logic [3:0]  mask_set;

    seg7_to_bcd u_dec (
        .seg  (smp_seg),
        .code (dec_code),
        .err  (dec_err)
    );

    assign smp_one_hot = is_one_hot(smp_en);
    assign smp_changed = {smp_en, smp_seg} != {prv_en, prv_seg};

    // Next-state logic. The counter value equals the number of identical
    // consecutive samples seen, so the capture fires on the edge where it
    // would step from STABLE_CNT-1 to STABLE_CNT. A change on that edge
    // reloads it to 1 instead, which suppresses the capture.
    always_comb begin
        fsm_n   = fsm_q;
        capture = 1'b0;
        case (fsm_q.state)
            ST_IDLE: begin
                if (smp_one_hot) begin
                    fsm_n.state = ST_SETTLE;
                    fsm_n.cnt   = 4'd1;
                end else begin
                    fsm_n.cnt   = 4'd0;
                end
            end
            ST_SETTLE: begin
                if (!smp_one_hot) begin
                    fsm_n.state = ST_IDLE;
                    fsm_n.cnt   = 4'd0;
                end else if (smp_changed) begin
                    fsm_n.cnt   = 4'd1;
                end else if (fsm_q.cnt == CNT_LAST) begin
                    capture     = 1'b1;
                    fsm_n.state = ST_HOLD;
                    fsm_n.cnt   = CNT_CAPTURE;
                end else begin
                    fsm_n.cnt   = fsm_q.cnt + 4'd1;
                end
            end
            ST_HOLD: begin
                if (!smp_one_hot) begin
                    fsm_n.state = ST_IDLE;
                    fsm_n.cnt   = 4'd0;
                end else if (smp_changed) begin
                    fsm_n.state = ST_SETTLE;
                    fsm_n.cnt   = 4'd1;
                end
            end
            default: begin
                fsm_n.state = ST_IDLE;
                fsm_n.cnt   = 4'd0;
            end
        endcase

        // Capture writes only the strobed nibble and err bit; the mask
        // clears on the same edge that completes it.
        mask_set = fsm_q.mask | smp_en;
        bcd_n    = bcd_q;
        err_n    = err_q;
        fv_n     = 1'b0;
        if (capture) begin
            for (int i = 0; i < 4; i++) begin
                if (smp_en[i]) begin
                    bcd_n[4*i +: 4] = dec_code;
                    err_n[i]        = dec_err;
                end
            end
            if (mask_set == 4'hF) begin
                fv_n       = 1'b1;
                fsm_n.mask = 4'd0;
            end else begin
                fsm_n.mask = mask_set;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_seg <= 7'd0;
            smp_en  <= 4'd0;
            prv_seg <= 7'd0;
            prv_en  <= 4'd0;
            se_q    <= 1'b0;
            fsm_q   <= '{state: ST_IDLE, cnt: 4'd0, mask: 4'd0};
            bcd_q   <= 16'h0000;
            err_q   <= 4'b0000;
            fv_q    <= 1'b0;
        end else begin
            smp_seg <= seg_in;
            smp_en  <= dig_en;
            prv_seg <= smp_seg;
            prv_en  <= smp_en;
            // Registered alongside the sample, independent of the FSM.
            se_q    <= is_multi_hot(dig_en);
            fsm_q   <= fsm_n;
            bcd_q   <= bcd_n;
            err_q   <= err_n;
            fv_q    <= fv_n;
        end
    end

    assign bcd_digits  = bcd_q;
    assign digit_err   = err_q;
    assign frame_valid = fv_q;
    assign scan_err    = se_q;

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CNT SHALL be: default 4; legal range 2..15; the number of consecutive samples of identical inputs required before a digit is captured.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-004 Port seg_in SHALL be: input, 7 bits, active-high segment lines {a,b,c,d,e,f,g}, with bit 6 = a and bit 0 = g.
REQ-005 Port dig_en SHALL be: input, 4 bits, active-high digit strobe of a multiplexed display; legal values are one-hot or zero.
REQ-006 Port bcd_digits SHALL be: output, 16 bits, decoded digits; digit i occupies bits [4i+3:4i].
REQ-007 Port digit_err SHALL be: output, 4 bits; bit i = last capture of digit i was an unrecognised pattern.
REQ-008 Port frame_valid SHALL be: output, 1 bit, one-cycle pulse when all four digits have been captured since the previous pulse.
REQ-009 Port scan_err SHALL be: output, 1 bit, one-cycle pulse on each sample where dig_en has more than one bit set.

Function
REQ-010 The decode table SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; every other pattern, including 1001111 ('E'), SHALL decode to 4'hF with err=1.
REQ-011 seg_in and dig_en SHALL be registered once per clock into a sample register; all decisions SHALL use the registered values.
REQ-012 The FSM SHALL have three states: IDLE, SETTLE, HOLD.
REQ-013 IDLE: sampled dig_en is zero or non-one-hot; the stability counter is held at 0; transitions to SETTLE when a one-hot sample arrives.
REQ-014 SETTLE: the counter increments while the sample equals the previous sample; any change in {dig_en,seg_in} reloads the counter to 1 and stays in SETTLE (or moves to IDLE if the new dig_en is not one-hot).
REQ-015 When the counter reaches STABLE_CNT, the FSM SHALL capture the digit: write the decoded code to the selected nibble and the err flag to the selected digit_err bit, set that bit of an internal 4-bit capture mask, and enter HOLD.
REQ-016 HOLD: no further capture while the inputs are unchanged; any change SHALL go to SETTLE with counter 1, or to IDLE if the new dig_en is not one-hot.
REQ-017 Latency: if the inputs are constant from rising edge k (first sampled at edge k+1), bcd_digits/digit_err SHALL update at edge k+1+STABLE_CNT.
REQ-018 Unselected nibbles and err bits SHALL retain their values on every capture.
REQ-019 When a capture completes the mask (all four bits set), frame_valid SHALL assert in the cycle following that capture edge, and the mask SHALL clear on the same edge; recapturing an already-set digit SHALL NOT pulse frame_valid.
REQ-020 scan_err SHALL be registered, aligned with the sample, and independent of the FSM state.
REQ-021 A change in inputs on the exact cycle the counter would reach STABLE_CNT SHALL suppress the capture.

Reset
REQ-022 On rst_n low, asynchronously: bcd_digits=16'h0000, digit_err=4'b0000, frame_valid=0, scan_err=0, sample register=0, counter=0, mask=0, FSM=IDLE.
REQ-023 A reset asserted mid-SETTLE or mid-frame SHALL discard all partial progress; the first frame_valid after reset requires four fresh captures.

Structure
REQ-024 Shared package seg7_pkg SHALL hold the ten segment-pattern constants, the error code 4'hF, and the FSM state encodings, shared with the existing BCD-to-7-segment encoder.
REQ-025 The combinational pattern lookup SHALL be a sub-module named seg7_to_bcd (input 7 bits; outputs 4-bit code and err); everything else lives in seg7_scan_decoder.

Verification
REQ-026 Reset, then dig_en=0001 with seg_in=1101101 held for 6 cycles -> bcd_digits[3:0]=2 exactly at edge 1+STABLE_CNT after the first presentation, and digit_err[0]=0.
REQ-027 Scan the digits 3 (0001), 7 (0010), 0 (0100), 9 (1000), 5 cycles each -> bcd_digits=16'h9073 and a single frame_valid pulse after the fourth capture.
REQ-028 dig_en=0100 with seg_in=1001111 -> bcd_digits[11:8]=4'hF and digit_err[2]=1.
REQ-029 seg_in toggles between 0110000 and 1111110 every 2 cycles with dig_en=0001 and STABLE_CNT=4 -> no capture, bcd_digits unchanged.
REQ-030 dig_en=0011 for 3 cycles -> scan_err pulses 3 times, no capture; then assert rst_n low mid-frame after 2 captures -> all outputs 0, and the next frame_valid only after 4 new captures.
